pwm_duty_capture: RTL and testbench

Multi-channel PWM duty-cycle measurement block; the receive-side counterpart of the serial-latched PWM generator. It samples up to `CHANNELS` PWM lines, counts high samples over a fixed window of `PERIOD` clocks, and publishes one duty value per channel at each window end. It also flags channels that stayed constantly high or constantly low for the whole window. It sits on the board-facing side of the PWM bank and feeds a status or monitor register file.

---
 rtl/pwm_duty_capture_if.sv | 33 +++
 rtl/pwm_duty_capture.sv | 129 ++++++++++++
 tb/tb_pwm_duty_capture.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_capture_if.sv
// pwm_duty_capture_if
//   Bundles the measurement-side signals of the PWM duty capture block.
//   master : drives the PWM lines and frame_sync, observes the results.
//   slave  : the capture block itself.
//   Signals:
//     pwm_in     [CHANNELS]        raw PWM lines (async to clk)
//     frame_sync                   synchronous window restart
//     duty_flat  [CHANNELS*CNT_W]  channel k count at [k*CNT_W +: CNT_W]
//     duty_valid                   one-cycle pulse when duty_flat updates
//     stuck_high / stuck_low       per-channel constant-level flags
//     window_cnt [CNT_W]           current position in the window
interface pwm_duty_capture_if #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]       pwm_in;
    logic                      frame_sync;
    logic [CHANNELS*CNT_W-1:0] duty_flat;
    logic                      duty_valid;
    logic [CHANNELS-1:0]       stuck_high;
    logic [CHANNELS-1:0]       stuck_low;
    logic [CNT_W-1:0]          window_cnt;

    modport master (
        output pwm_in, frame_sync,
        input  duty_flat, duty_valid, stuck_high, stuck_low, window_cnt
    );

    modport slave (
        input  pwm_in, frame_sync,
        output duty_flat, duty_valid, stuck_high, stuck_low, window_cnt
    );
endinterface

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture
//   Measures the duty cycle of CHANNELS PWM lines over a free-running window
//   of PERIOD clocks and publishes one count per channel at each window end,
//   together with stuck-high / stuck-low flags for the completed window.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high
//     bus   : pwm_duty_capture_if.slave (PWM inputs, frame_sync, results)

// One measurement lane: synchronizer, accumulator and published result.
module pwm_duty_capture_lane #(
    parameter int PERIOD = 101,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm,
    input  logic             clr,      // frame_sync: drop the partial window
    input  logic             publish,  // terminal cycle not overridden by clr
    output logic [CNT_W-1:0] duty,
    output logic             stuck_high,
    output logic             stuck_low
);
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             stuck_high_q, stuck_high_d;
    logic             stuck_low_q, stuck_low_d;
    logic [CNT_W-1:0] sum;

    always_comb begin
        sync1_d      = pwm;
        sync2_d      = sync1_q;
        // The final sample of the window is folded in on the publish edge.
        sum          = acc_q + {{(CNT_W-1){1'b0}}, sync2_q};
        acc_d        = (clr || publish) ? '0 : sum;
        duty_d       = duty_q;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;
        if (publish) begin
            duty_d       = sum;
            stuck_high_d = (sum == CNT_W'(PERIOD));
            stuck_low_d  = (sum == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            acc_q        <= '0;
            duty_q       <= '0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            acc_q        <= acc_d;
            duty_q       <= duty_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign duty       = duty_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;
endmodule

module pwm_duty_capture #(
    parameter int CHANNELS = 8,
    parameter int PERIOD   = 101,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    pwm_duty_capture_if.slave   bus
);
    logic [CNT_W-1:0]                 window_cnt_q, window_cnt_d;
    logic                             duty_valid_q, duty_valid_d;
    logic                             term;
    logic                             publish;
    logic [CHANNELS-1:0][CNT_W-1:0]   duty;
    logic [CHANNELS-1:0]              stuck_high;
    logic [CHANNELS-1:0]              stuck_low;

    // frame_sync beats the terminal cycle: the window is restarted and
    // nothing is published.
    always_comb begin
        term         = (window_cnt_q == CNT_W'(PERIOD - 1));
        publish      = term && !bus.frame_sync;
        window_cnt_d = (term || bus.frame_sync) ? '0 : window_cnt_q + 1'b1;
        duty_valid_d = publish;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window_cnt_q <= '0;
            duty_valid_q <= 1'b0;
        end else begin
            window_cnt_q <= window_cnt_d;
            duty_valid_q <= duty_valid_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        pwm_duty_capture_lane #(
            .PERIOD (PERIOD),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .pwm        (bus.pwm_in[k]),
            .clr        (bus.frame_sync),
            .publish    (publish),
            .duty       (duty[k]),
            .stuck_high (stuck_high[k]),
            .stuck_low  (stuck_low[k])
        );
    end

    // Packed [CHANNELS][CNT_W] places channel k at [k*CNT_W +: CNT_W].
    assign bus.duty_flat  = duty;
    assign bus.duty_valid = duty_valid_q;
    assign bus.stuck_high = stuck_high;
    assign bus.stuck_low  = stuck_low;
    assign bus.window_cnt = window_cnt_q;
endmodule

// File: tb/tb_pwm_duty_capture.sv
// tb_pwm_duty_capture
//   Table-driven windows checked through an expectation queue, plus
//   hand-written frame_sync and mid-window reset sequences.
module tb_pwm_duty_capture;
    localparam int CH = 8;
    localparam int P  = 101;
    localparam int W  = 8;
    localparam int NV = 6;

    typedef struct {
        logic [CH*W-1:0] duty;
        logic [CH-1:0]   sh;
        logic [CH-1:0]   sl;
    } exp_t;

    typedef struct {
        int   len [CH];   // high samples per window for each channel
        exp_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    pwm_duty_capture_if #(.CHANNELS(CH), .CNT_W(W)) bus ();

    pwm_duty_capture #(.CHANNELS(CH), .PERIOD(P), .CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   tests  = 0;
    int   fails  = 0;
    int   pos    = 0;     // expected window_cnt
    int   cyc    = 0;
    int   last_v = -1;
    bit   gap_chk = 1'b0;
    exp_t q[$];
    exp_t last_exp;
    int   cur_len [CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One clock: drive frame_sync, sample #1 after the edge, compare.
    task automatic step(input logic fs);
        logic ev;
        exp_t e;
        bus.frame_sync = fs;
        @(posedge clk);
        #1;
        ev  = (pos == P - 1) && !fs;
        pos = (fs || pos == P - 1) ? 0 : pos + 1;
        cyc++;
        chk("window_cnt", 64'(bus.window_cnt), 64'(pos));
        chk("duty_valid", 64'(bus.duty_valid), 64'(ev));
        if (bus.duty_valid) begin
            if (gap_chk && last_v >= 0) chk("valid_gap", 64'(cyc - last_v), 64'(P));
            last_v = cyc;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL publish: duty_valid with no expected window");
            end else begin
                e = q.pop_front();
                last_exp = e;
                chk("duty_flat", bus.duty_flat, e.duty);
                chk("stuck_high", 64'(bus.stuck_high), 64'(e.sh));
                chk("stuck_low", 64'(bus.stuck_low), 64'(e.sl));
            end
        end
    endtask

    task automatic advance_to(input int target);
        for (int n = 0; n < 2 * P && pos != target; n++) step(1'b0);
    endtask

    // Run one window and require the publish exactly P cycles later.
    task automatic run_window(input string name);
        int vn;
        vn = 0;
        for (int n = 1; n <= P; n++) begin
            step(1'b0);
            if (bus.duty_valid && vn == 0) vn = n;
        end
        chk(name, 64'(vn), 64'(P));
    endtask

    initial begin
        vec_t tab [NV];
        exp_t ez, ea5, ea5r;
        int   vidx;

        tab[0].len      = '{10, 20, 30, 40, 50, 60, 70, 80};
        tab[0].exp.duty = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        tab[0].exp.sh   = 8'h00;
        tab[0].exp.sl   = 8'h00;
        tab[1].len      = '{101, 0, 0, 0, 0, 0, 0, 0};
        tab[1].exp.duty = {56'd0, 8'd101};
        tab[1].exp.sh   = 8'h01;
        tab[1].exp.sl   = 8'hFE;
        tab[2]          = tab[1];
        tab[3].len      = '{0, 0, 0, 0, 0, 0, 0, 0};
        tab[3].exp.duty = '0;
        tab[3].exp.sh   = 8'h00;
        tab[3].exp.sl   = 8'hFF;
        tab[4].len      = '{101, 101, 101, 101, 101, 101, 101, 101};
        tab[4].exp.duty = {8{8'd101}};
        tab[4].exp.sh   = 8'hFF;
        tab[4].exp.sl   = 8'h00;
        tab[5].len      = '{0, 1, 100, 101, 50, 99, 2, 0};
        tab[5].exp.duty = {8'd0, 8'd2, 8'd99, 8'd50, 8'd101, 8'd100, 8'd1, 8'd0};
        tab[5].exp.sh   = 8'h08;
        tab[5].exp.sl   = 8'h81;

        ez.duty  = '0;
        ez.sh    = 8'h00;
        ez.sl    = 8'hFF;
        ea5.duty = {8'd101, 8'd0, 8'd101, 8'd0, 8'd0, 8'd101, 8'd0, 8'd101};
        ea5.sh   = 8'hA5;
        ea5.sl   = 8'h5A;
        // First window after reset: two flush zeros, so 99 high samples.
        ea5r.duty = {8'd99, 8'd0, 8'd99, 8'd0, 8'd0, 8'd99, 8'd0, 8'd99};
        ea5r.sh   = 8'h00;
        ea5r.sl   = 8'h5A;

        bus.pwm_in     = '0;
        bus.frame_sync = 1'b0;
        reset          = 1'b0;
        #1 reset = 1'b1;
        #10;
        chk("rst_window_cnt", 64'(bus.window_cnt), 64'd0);
        chk("rst_duty_flat", bus.duty_flat, 64'd0);
        chk("rst_duty_valid", 64'(bus.duty_valid), 64'd0);
        chk("rst_stuck_high", 64'(bus.stuck_high), 64'd0);
        chk("rst_stuck_low", 64'(bus.stuck_low), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pos   = 0;

        // Table windows. Each pattern is started 2 cycles ahead of its window
        // so the synchronizer delay lines the samples up with the window.
        q.push_back(ez);
        for (int k = 0; k < CH; k++) cur_len[k] = 0;
        vidx    = 0;
        gap_chk = 1'b1;
        for (int n = 0; n < 12 * P && !(vidx == NV && q.size() == 0); n++) begin
            int vp;
            vp = (pos + 2) % P;
            if (vp == 0) begin
                if (vidx < NV) begin
                    cur_len = tab[vidx].len;
                    q.push_back(tab[vidx].exp);
                    vidx++;
                end else begin
                    for (int k = 0; k < CH; k++) cur_len[k] = 0;
                end
            end
            for (int k = 0; k < CH; k++) bus.pwm_in[k] = (vp < cur_len[k]);
            step(1'b0);
        end
        chk("table_drained", 64'(q.size()), 64'd0);
        gap_chk = 1'b0;

        // frame_sync mid-window: old terminal point skipped, publish P later.
        bus.pwm_in = 8'hA5;
        advance_to(50);
        step(1'b1);
        chk("fs50_duty_held", bus.duty_flat, last_exp.duty);
        q.push_back(ea5);
        run_window("fs50_to_valid");

        // frame_sync on the terminal cycle: no publish, window restarts.
        advance_to(P - 1);
        step(1'b1);
        chk("fs100_duty_held", bus.duty_flat, ea5.duty);
        chk("fs100_sh_held", 64'(bus.stuck_high), 64'(ea5.sh));
        q.push_back(ea5);
        run_window("fs100_next_valid");

        // frame_sync held: window_cnt pinned at 0, never a publish.
        for (int n = 0; n < 150; n++) step(1'b1);

        // Reset at window_cnt=60 clears everything without a clock.
        advance_to(60);
        #2 reset = 1'b1;
        #1;
        chk("arst_duty_flat", bus.duty_flat, 64'd0);
        chk("arst_duty_valid", 64'(bus.duty_valid), 64'd0);
        chk("arst_stuck_high", 64'(bus.stuck_high), 64'd0);
        chk("arst_stuck_low", 64'(bus.stuck_low), 64'd0);
        chk("arst_window_cnt", 64'(bus.window_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pos   = 0;
        q.push_back(ea5r);
        run_window("arst_first_valid");
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
